// File: rtl/shift_serial.sv
// Multi-cycle shifter: one command per start pulse, one bit position per clock, one-cycle done pulse.
// Define SHIFT_SERIAL_ROTATE_EN to build ROL/ROR (codes 3 and 4); otherwise those codes pass through.
module shift_serial #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] data,
  input  logic [2:0]   shift,
  input  logic [2:0]   direccion,
  output logic [n-1:0] y,
  output logic         carry,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [2:0]   count;
  logic [2:0]   op;
  logic         op_valid;
  logic [n-1:0] step_y;
  logic         step_carry;

  // Codes without an implemented operation are loaded with a zero count.
  always_comb begin
`ifdef SHIFT_SERIAL_ROTATE_EN
    op_valid = (direccion <= 3'd4);
`else
    op_valid = (direccion <= 3'd2);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == 3'd0) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One-bit step of the captured operation; carry is the bit leaving the word.
  always_comb begin
    step_y     = y;
    step_carry = carry;
    case (op)
      3'd0: begin
        step_y     = {y[n-2:0], 1'b0};
        step_carry = y[n-1];
      end
      3'd1: begin
        step_y     = {1'b0, y[n-1:1]};
        step_carry = y[0];
      end
      3'd2: begin
        step_y     = {y[n-1], y[n-1:1]};
        step_carry = y[0];
      end
`ifdef SHIFT_SERIAL_ROTATE_EN
      3'd3: begin
        step_y     = {y[n-2:0], y[n-1]};
        step_carry = y[n-1];
      end
      3'd4: begin
        step_y     = {y[0], y[n-1:1]};
        step_carry = y[0];
      end
`endif
      default: begin
        step_y     = y;
        step_carry = carry;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y     <= '0;
      carry <= 1'b0;
      count <= 3'd0;
      op    <= 3'd0;
    end else if (state == IDLE && start) begin
      y     <= data;
      carry <= 1'b0;
      count <= op_valid ? shift : 3'd0;
      op    <= direccion;
    end else if (state == SHIFT && count != 3'd0) begin
      y     <= step_y;
      carry <= step_carry;
      count <= count - 3'd1;
    end
  end

endmodule

// File: tb/tb_shift_serial.sv
// Directed bench for shift_serial (n=4): result, carry, latency, busy length, start-ignore and mid-op reset.
module tb_shift_serial;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] data = '0;
  logic [2:0]   shift = 3'd0;
  logic [2:0]   direccion = 3'd0;
  logic [N-1:0] y;
  logic         carry;
  logic         busy;
  logic         done;

  int           vectors = 0;
  int           miscompares = 0;
  logic [N:0]   exp_q[$];

  shift_serial #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .shift     (shift),
    .direccion (direccion),
    .y         (y),
    .carry     (carry),
    .busy      (busy),
    .done      (done)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command, then scramble the inputs to show they are not reused after capture.
  task automatic run_cmd(input string tag, input logic [N-1:0] d, input logic [2:0] s,
                         input logic [2:0] c, input logic [N-1:0] ey, input logic ec,
                         input int elat);
    int         lat;
    int         busy_cycles;
    logic [N:0] expv;
    @(negedge clk);
    data      = d;
    shift     = s;
    direccion = c;
    start     = 1'b1;
    exp_q.push_back({ec, ey});
    @(posedge clk);
    #1;
    start     = 1'b0;
    data      = N'($urandom_range(0, 15));
    shift     = 3'($urandom_range(0, 7));
    direccion = 3'($urandom_range(0, 7));
    lat         = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, busy_cycles, elat - 1);
    expv = exp_q.pop_front();
    check({tag, " y"}, y, expv[N-1:0]);
    check({tag, " carry"}, carry, expv[N]);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " y_held"}, y, expv[N-1:0]);
  endtask

  initial begin
    logic seen_done;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset y", y, 0);
    check("reset carry", carry, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    rst = 1'b1;

    run_cmd("lsl_1100_2", 4'b1100, 3'd2, 3'd0, 4'b0000, 1'b1, 4);
    run_cmd("lsr_1101_1", 4'b1101, 3'd1, 3'd1, 4'b0110, 1'b1, 3);
    run_cmd("asr_1000_3", 4'b1000, 3'd3, 3'd2, 4'b1111, 1'b0, 5);
`ifdef SHIFT_SERIAL_ROTATE_EN
    run_cmd("rol_1001_1", 4'b1001, 3'd1, 3'd3, 4'b0011, 1'b1, 3);
    run_cmd("ror_0110_5", 4'b0110, 3'd5, 3'd4, 4'b0011, 1'b0, 7);
`else
    run_cmd("rol_1001_1", 4'b1001, 3'd1, 3'd3, 4'b1001, 1'b0, 2);
    run_cmd("ror_0110_5", 4'b0110, 3'd5, 3'd4, 4'b0110, 1'b0, 2);
`endif
    run_cmd("pass7_1010_6", 4'b1010, 3'd6, 3'd7, 4'b1010, 1'b0, 2);
    run_cmd("lsl_0101_5", 4'b0101, 3'd5, 3'd0, 4'b0000, 1'b0, 7);
    run_cmd("lsr_1011_7", 4'b1011, 3'd7, 3'd1, 4'b0000, 1'b0, 9);
    run_cmd("asr_1010_6", 4'b1010, 3'd6, 3'd2, 4'b1111, 1'b1, 8);
    run_cmd("lsl_1001_0", 4'b1001, 3'd0, 3'd0, 4'b1001, 1'b0, 2);
    run_cmd("asr_0110_4", 4'b0110, 3'd4, 3'd2, 4'b0000, 1'b0, 6);

    // Long command, ignored start at cycle 2, reset at cycle 4.
    @(negedge clk);
    data      = 4'b0101;
    shift     = 3'd7;
    direccion = 3'd0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort busy_after_accept", busy, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    data      = 4'b1111;
    shift     = 3'd0;
    direccion = 3'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort start_ignored busy", busy, 1'b1);
    check("abort start_ignored done", done, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort y", y, 0);
    check("abort busy", busy, 0);
    check("abort carry", carry, 0);
    seen_done = done;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done | busy;
    end
    check("abort no_done", seen_done, 1'b0);
    run_cmd("after_reset_0011_0", 4'b0011, 3'd0, 3'd0, 4'b0011, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
